wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue between the execute/memory stages and the register file. Accepts up to three write requests per cycle (ALU port 1, ALU port 2, load) into a small in-order FIFO and retires exactly one per cycle onto register-file write port 1, so simultaneous writes are never dropped by the register file's priority logic. Also exports a pending-write scoreboard and two forwarding lookups for the hazard/operand stage.

## Interface
- DEPTH, 4, FIFO entries; legal range 4..16.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req1_valid / req1_addr / req1_data  in  1/4/32  ALU port-1 write request.
- req2_valid / req2_addr / req2_data  in  1/4/32  ALU port-2 write request.
- reqL_valid / reqL_addr / reqL_data  in  1/4/32  load write request.
- stall_o  out  1  queue cannot accept a worst-case 3-request cycle; upstream must hold.
- w_en_o / w_addr_o / w_data_o  out  1/4/32  to register-file w_en1/w_addr1/w_data1.
- busy_o  out  16  bit r set when any queued entry targets register r.
- fwd_addr_a, fwd_addr_b  in  4  lookup addresses.
- fwd_hit_a, fwd_hit_b  out  1  youngest queued entry matches address.
- fwd_data_a, fwd_data_b  out  32  data of that entry; 0 when no hit.

## Operation
- Acceptance: requests accepted only when stall_o=0; when stall_o=1 all req*_valid are ignored.
- Filtering: request with addr 0 is discarded (R0 hardwired zero), never queued, never sets busy.
- Push order within a cycle: req1, then req2, then reqL; older = lower slot index. 0..3 pushes per cycle.
- Pop: when queue non-empty, head is presented on w_*_o and removed at the clock edge (register file consumes unconditionally).
- Push and pop in the same cycle allowed; count_next = count + pushes − pop.
- Empty: w_en_o=0, w_addr_o=0, w_data_o=0.
- stall_o = (count > DEPTH−3), from registered count only.
- R15 entries queued like any other; PC-load override is the register file's concern.
- busy_o: OR over valid entries of one-hot(addr); bit 0 always 0.
- Forwarding: scan valid entries head→tail, keep last match (youngest). addr 0 → hit=0, data=0. Same-cycle incoming requests are not visible.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).

## Timing
- Request accepted at edge N → earliest on w_*_o during cycle N+1 → written into register file at edge ending N+1.
- busy_o, fwd_*, stall_o, w_*_o are combinational from registered state only (no input-to-output paths except fwd_addr→fwd_*).
- Reset (rst_n=0 at edge): count=0, pointers=0; next cycle w_en_o=0, w_addr_o=0, w_data_o=0, busy_o=0, stall_o=0, fwd_hit=0. Requests and pending entries in that cycle are dropped; reset mid-drain discards the queue.
- Full boundary: never overflows, since stall_o guarantees ≥3 free slots whenever acceptance is enabled.
- Duplicate address in one cycle (e.g. req1 and reqL both R5): both queued in order; register file sees req1 then reqL; final R5 = reqL data.

## Structure
- Package wb_pkg: wb_req_t struct {addr[3:0], data[31:0]}; constants REG_ZERO=4'd0, REG_PC=4'd15; function for youngest-match lookup over the entry array.
- Single module, no sub-module; storage is an array of wb_req_t plus valid-by-count logic.
- Register-file ports w_en2 and w_en_ldr tied low at integration.

## Test plan
- Single write: req1 R3=0x11 at cycle 0 → cycle 1 w_en_o=1, w_addr_o=3, w_data_o=0x11; busy_o[3]=1 in cycle 1, 0 in cycle 2.
- Triple write: req1 R1=0xA, req2 R2=0xB, reqL R3=0xC same cycle → written R1, R2, R3 in cycles 1,2,3; stall_o=1 in cycles 1–2 (count 3,2 > 1) and 0 in cycle 3 (count 1).
- R0 filter: req1 R0=0xFF, req2 R4=0x5 → only R4 queued; busy_o=0x0010; w_addr_o never 0 with w_en_o=1.
- Forwarding: queue R6=0x1 then R6=0x2 (req1, req2) → fwd_addr_a=6 gives hit=1, data=0x2; after first pop still 0x2; fwd_addr_b=0 gives hit=0.
- Backpressure: while stall_o=1 drive req1 R7=0x9 → not queued, never appears on w_*_o.
- Reset mid-drain: 3 entries queued, rst_n=0 one cycle → next cycle w_en_o=0, busy_o=0, stall_o=0; queued data never written.

Source files
------------

// File: rtl/wb_queue_pkg.sv
// Shared types for the writeback queue: entry layout, fixed register numbers
// and the youngest-match forwarding lookup used by the hazard stage.
package wb_pkg;

  localparam int         MAX_DEPTH = 16;
  localparam logic [3:0] REG_ZERO  = 4'd0;
  localparam logic [3:0] REG_PC    = 4'd15;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } fwd_t;

  // ents is ordered oldest (index 0) to youngest; the last valid match wins
  function automatic fwd_t youngest_match(input wb_req_t [MAX_DEPTH-1:0] ents,
                                          input logic [MAX_DEPTH-1:0]    vld,
                                          input logic [3:0]              addr);
    fwd_t r;
    r = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (vld[i] && (addr != REG_ZERO) && (ents[i].addr == addr)) begin
        r.hit  = 1'b1;
        r.data = ents[i].data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Write-request side (three producers) and register-file write port of the
// writeback queue; master is the pipeline/bench, slave is the queue.
interface wb_queue_if;
  logic        req1_valid;
  logic [3:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req2_valid;
  logic [3:0]  req2_addr;
  logic [31:0] req2_data;
  logic        reqL_valid;
  logic [3:0]  reqL_addr;
  logic [31:0] reqL_data;
  logic        stall_o;
  logic        w_en_o;
  logic [3:0]  w_addr_o;
  logic [31:0] w_data_o;

  modport master (
    output req1_valid, req1_addr, req1_data,
    output req2_valid, req2_addr, req2_data,
    output reqL_valid, reqL_addr, reqL_data,
    input  stall_o, w_en_o, w_addr_o, w_data_o
  );

  modport slave (
    input  req1_valid, req1_addr, req1_data,
    input  req2_valid, req2_addr, req2_data,
    input  reqL_valid, reqL_addr, reqL_data,
    output stall_o, w_en_o, w_addr_o, w_data_o
  );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback FIFO: up to 3 pushes per cycle, one pop per cycle to the
// register file, plus a pending-write scoreboard and two forwarding lookups.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_queue_if.slave   bus,
  output logic [15:0] busy_o,
  input  logic [3:0]  fwd_addr_a,
  input  logic [3:0]  fwd_addr_b,
  output logic        fwd_hit_a,
  output logic        fwd_hit_b,
  output logic [31:0] fwd_data_a,
  output logic [31:0] fwd_data_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t                   mem [DEPTH];
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [CW-1:0]             count;
  wb_req_t                   in_req [3];
  logic [2:0]                in_vld;
  logic [PW-1:0]             slot [3];
  logic [1:0]                push_cnt;
  logic                      pop;
  logic                      accept;
  wb_req_t [MAX_DEPTH-1:0]   ordered;
  logic [MAX_DEPTH-1:0]      ord_vld;
  fwd_t                      fwd_a;
  fwd_t                      fwd_b;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  // stall keeps three slots free, so an accepted worst-case cycle never overflows
  assign accept       = (int'(count) <= (DEPTH - 3));
  assign bus.stall_o  = !accept;
  assign pop          = (count != '0);
  assign bus.w_en_o   = pop;
  assign bus.w_addr_o = pop ? mem[head].addr : '0;
  assign bus.w_data_o = pop ? mem[head].data : '0;

  always_comb begin
    in_req[0] = {bus.req1_addr, bus.req1_data};
    in_req[1] = {bus.req2_addr, bus.req2_data};
    in_req[2] = {bus.reqL_addr, bus.reqL_data};
    in_vld[0] = accept && bus.req1_valid && (bus.req1_addr != REG_ZERO);
    in_vld[1] = accept && bus.req2_valid && (bus.req2_addr != REG_ZERO);
    in_vld[2] = accept && bus.reqL_valid && (bus.reqL_addr != REG_ZERO);
    push_cnt  = 2'd0;
    for (int i = 0; i < 3; i++) begin
      slot[i] = wrap_add(tail, int'(push_cnt));
      if (in_vld[i]) push_cnt = push_cnt + 2'd1;
    end
  end

  // Queue contents rearranged oldest-first for the scoreboard and lookups
  always_comb begin
    ordered = '0;
    ord_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i] = mem[wrap_add(head, i)];
      ord_vld[i] = (i < int'(count));
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (ord_vld[i]) busy_o[ordered[i].addr] = 1'b1;
    end
    busy_o[REG_ZERO] = 1'b0;
  end

  assign fwd_a      = youngest_match(ordered, ord_vld, fwd_addr_a);
  assign fwd_b      = youngest_match(ordered, ord_vld, fwd_addr_b);
  assign fwd_hit_a  = fwd_a.hit;
  assign fwd_data_a = fwd_a.data;
  assign fwd_hit_b  = fwd_b.hit;
  assign fwd_data_b = fwd_b.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (in_vld[i]) mem[slot[i]] <= in_req[i];
      end
      tail  <= wrap_add(tail, int'(push_cnt));
      if (pop) head <= wrap_add(head, 1);
      count <= count + CW'(push_cnt) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: accepted requests are queued in the bench
// model and compared against the register-file write port each cycle.
module tb_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] busy_o;
  logic [3:0]  fwd_a;
  logic [3:0]  fwd_b;
  logic        fwd_hit_a;
  logic        fwd_hit_b;
  logic [31:0] fwd_data_a;
  logic [31:0] fwd_data_b;

  wb_queue_if bus ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy_o),
    .fwd_addr_a (fwd_a),
    .fwd_addr_b (fwd_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data_a (fwd_data_a),
    .fwd_data_b (fwd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        sb [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        s_v [3];
  logic [3:0]  s_a [3];
  logic [31:0] s_d [3];
  logic        s_rst;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] fwd_model(input logic [3:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 4'd0) begin
      foreach (sb[i]) if (sb[i].a == a) r = {1'b1, sb[i].d};
    end
    return r;
  endfunction

  task automatic stage(input int port, input logic [3:0] a, input logic [31:0] d);
    s_v[port] = 1'b1;
    s_a[port] = a;
    s_d[port] = d;
  endtask

  // Check the cycle just completed, retire the head, then drive the staged inputs
  task automatic tick();
    int          cnt;
    logic        acc;
    logic [15:0] eb;
    logic [32:0] fa;
    logic [32:0] fb;
    @(negedge clk);
    cnt = sb.size();
    acc = (cnt <= DEPTH - 3);
    chk("stall", 32'(bus.stall_o), 32'(!acc));
    if (cnt > 0) begin
      chk("w_en", 32'(bus.w_en_o), 32'd1);
      chk("w_addr", 32'(bus.w_addr_o), 32'(sb[0].a));
      chk("w_data", bus.w_data_o, sb[0].d);
    end else begin
      chk("w_en", 32'(bus.w_en_o), 32'd0);
      chk("w_addr", 32'(bus.w_addr_o), 32'd0);
      chk("w_data", bus.w_data_o, 32'd0);
    end
    eb = '0;
    foreach (sb[i]) eb[sb[i].a] = 1'b1;
    eb[0] = 1'b0;
    chk("busy", 32'(busy_o), 32'(eb));
    fa = fwd_model(fwd_a);
    fb = fwd_model(fwd_b);
    chk("fwd_hit_a", 32'(fwd_hit_a), 32'(fa[32]));
    chk("fwd_data_a", fwd_data_a, fa[31:0]);
    chk("fwd_hit_b", 32'(fwd_hit_b), 32'(fb[32]));
    chk("fwd_data_b", fwd_data_b, fb[31:0]);
    if (cnt > 0) void'(sb.pop_front());

    bus.req1_valid = s_v[0]; bus.req1_addr = s_a[0]; bus.req1_data = s_d[0];
    bus.req2_valid = s_v[1]; bus.req2_addr = s_a[1]; bus.req2_data = s_d[1];
    bus.reqL_valid = s_v[2]; bus.reqL_addr = s_a[2]; bus.reqL_data = s_d[2];
    rst_n = !s_rst;
    if (s_rst) begin
      sb.delete();
    end else if (acc) begin
      for (int k = 0; k < 3; k++) begin
        if (s_v[k] && s_a[k] != 4'd0) sb.push_back('{a: s_a[k], d: s_d[k]});
      end
    end
    for (int k = 0; k < 3; k++) begin
      s_v[k] = 1'b0;
      s_a[k] = '0;
      s_d[k] = '0;
    end
    s_rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_v[k] = 1'b0;
      s_a[k] = '0;
      s_d[k] = '0;
    end
    s_rst = 1'b0;
    fwd_a = 4'd0;
    fwd_b = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.req2_valid = 1'b0; bus.req2_addr = '0; bus.req2_data = '0;
    bus.reqL_valid = 1'b0; bus.reqL_addr = '0; bus.reqL_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single write, visible one cycle after acceptance
    fwd_a = 4'd3;
    stage(0, 4'd3, 32'h11);
    repeat (3) tick();

    // triple write; a request presented while stalled must be ignored
    stage(0, 4'd1, 32'hA);
    stage(1, 4'd2, 32'hB);
    stage(2, 4'd3, 32'hC);
    tick();
    stage(0, 4'd7, 32'h9);
    repeat (5) tick();

    // R0 filter
    stage(0, 4'd0, 32'hFF);
    stage(1, 4'd4, 32'h5);
    repeat (3) tick();

    // forwarding picks the youngest of two R6 writes
    fwd_a = 4'd6;
    fwd_b = 4'd0;
    stage(0, 4'd6, 32'h1);
    stage(1, 4'd6, 32'h2);
    repeat (4) tick();

    // duplicate address: req1 then reqL, plus R15
    stage(0, 4'd5, 32'h55);
    stage(1, 4'd15, 32'hF0);
    stage(2, 4'd5, 32'h66);
    fwd_a = 4'd5;
    fwd_b = 4'd15;
    repeat (5) tick();

    // reset mid-drain discards the queue and any same-cycle request
    stage(0, 4'd8, 32'h80);
    stage(1, 4'd9, 32'h90);
    stage(2, 4'd10, 32'hA0);
    tick();
    s_rst = 1'b1;
    stage(0, 4'd11, 32'hB0);
    tick();
    repeat (3) tick();

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 2) != 0)
          stage(k, 4'($urandom_range(0, 15)), $urandom);
      end
      fwd_a = 4'($urandom_range(0, 15));
      fwd_b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) s_rst = 1'b1;
      tick();
    end
    for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
    tick();
    chk("drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
